// File: rtl/mpmc11_to_wdog.sv
// Shared state type for the MPMC11 controller channels and a per-channel
// stuck-state watchdog that counts how long each channel sits in one
// non-IDLE state and raises a timeout strobe / sticky flag when a shared
// threshold is reached. There are no valid/ready handshakes here: every
// input is sampled on each rising clk edge and every output is a plain level.

package mpmc11_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ACT  = 3'd2,
        RD   = 3'd3,
        WR   = 3'd4,
        PRE  = 3'd5,
        REF  = 3'd6,
        ERR  = 3'd7
    } mpmc11_state_t;
endpackage

module mpmc11_to_wdog
    import mpmc11_pkg::*;
#(
    parameter int NCH               = 4,
    parameter int CW                = 16,
    parameter int RESTART_ON_CHANGE = 0,
    localparam int CHW              = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  mpmc11_state_t [NCH-1:0]       state,
    input  mpmc11_state_t [NCH-1:0]       prev_state,
    input  logic          [NCH-1:0]       en,
    input  logic          [CW-1:0]        limit,
    input  logic          [NCH-1:0]       clr,
    input  logic                          ev_clr,
    output logic          [NCH-1:0][CW-1:0] to_cnt,
    output logic          [NCH-1:0]       to_pulse,
    output logic          [NCH-1:0]       to_flag,
    output logic                          to_any,
    output logic          [CHW-1:0]       to_chan,
    output logic          [7:0]           to_events
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [7:0]    EV_MAX  = 8'hFF;

    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]         pulse_q, pulse_d;
    logic [NCH-1:0]         flag_q, flag_d;
    logic [7:0]             ev_q, ev_d;
    logic [7:0]             new_pulses;
    logic [8:0]             ev_sum;

    // Per-channel rule priority: idle/disabled, state change, timeout, count.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (state[i] == IDLE || !en[i]) begin
                cnt_d[i] = '0;
            end else if (state[i] != prev_state[i]) begin
                // A fresh state either restarts the count or freezes it for this cycle.
                if (RESTART_ON_CHANGE != 0) begin
                    cnt_d[i] = '0;
                end
            end else if (limit != '0 && cnt_q[i] >= limit) begin
                // >= so a limit lowered below the running count fires right away.
                cnt_d[i]   = '0;
                pulse_d[i] = 1'b1;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Sticky flags: a new timeout beats a simultaneous clear.
    always_comb begin
        flag_d = pulse_d | (flag_q & ~clr);
    end

    // Event total: add this edge's new pulses, saturate at 255; ev_clr restarts from them.
    always_comb begin
        new_pulses = '0;
        for (int i = 0; i < NCH; i++) begin
            new_pulses = new_pulses + 8'(pulse_d[i]);
        end
        ev_sum = {1'b0, ev_q} + {1'b0, new_pulses};
        if (ev_clr) begin
            ev_d = new_pulses;
        end else if (ev_sum[8]) begin
            ev_d = EV_MAX;
        end else begin
            ev_d = ev_sum[7:0];
        end
    end

    // All watchdog state, cleared at once by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
            ev_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            ev_q    <= ev_d;
        end
    end

    // Lowest-numbered flagged channel, 0 when nothing is flagged.
    always_comb begin
        logic found;
        to_chan = '0;
        found   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (flag_q[i] && !found) begin
                to_chan = CHW'(i);
                found   = 1'b1;
            end
        end
    end

    assign to_cnt    = cnt_q;
    assign to_pulse  = pulse_q;
    assign to_flag   = flag_q;
    assign to_any    = |flag_q;
    assign to_events = ev_q;

endmodule

// File: doc/mpmc11_to_wdog.md
MPMC11_TO_WDOG -- requirements
Module: mpmc11_to_wdog

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of monitored state-machine channels (1..16).
REQ-002 SHALL have parameter CW, default 16, meaning per-channel timeout counter width (10..32).
REQ-003 SHALL have parameter RESTART_ON_CHANGE, default 0, meaning 1 clears the counter on a state change and 0 holds it.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, which is asynchronous and active-high.
REQ-006 SHALL have port state, input, NCH x mpmc11_state_t, meaning the current state of each channel.
REQ-007 SHALL have port prev_state, input, NCH x mpmc11_state_t, meaning the previous-cycle state of each channel.
REQ-008 SHALL have port en, input, NCH, meaning per-channel watchdog enable.
REQ-009 SHALL have port limit, input, CW, meaning the shared timeout threshold; 0 disables timeout detection.
REQ-010 SHALL have port clr, input, NCH, meaning per-channel sticky-flag clear.
REQ-011 SHALL have port ev_clr, input, 1, meaning event-counter clear.
REQ-012 SHALL have port to_cnt, output, NCH x CW, meaning per-channel registered counter.
REQ-013 SHALL have port to_pulse, output, NCH, meaning registered one-cycle timeout strobe.
REQ-014 SHALL have port to_flag, output, NCH, meaning registered sticky timeout status.
REQ-015 SHALL have port to_any, output, 1, meaning the combinational OR of to_flag.
REQ-016 SHALL have port to_chan, output, max(1,$clog2(NCH)), meaning the combinational lowest index with to_flag set, or 0 if none.
REQ-017 SHALL have port to_events, output, 8, meaning the registered saturating total timeout count.

Function
REQ-018 Each channel SHALL evaluate the following per clock, with the first matching rule winning.
REQ-019 Rule a: state==IDLE or en==0 -> to_cnt<=0, no pulse.
REQ-020 Rule b: state!=prev_state -> to_cnt<=0 if RESTART_ON_CHANGE=1, otherwise to_cnt is held; no pulse.
REQ-021 Rule c: limit!=0 and to_cnt>=limit -> to_cnt<=0 and to_pulse<=1 on the same edge.
REQ-022 Rule d: otherwise, to_cnt<=to_cnt+1, saturating at all-ones (this only occurs when limit==0).
REQ-023 to_pulse[i] SHALL be high for exactly one cycle per timeout and is 0 on every cycle where rule c does not fire.
REQ-024 The >= compare SHALL make a lowered limit fire on the next rule-c-qualifying cycle when to_cnt already exceeds it.
REQ-025 to_flag[i] SHALL be set on the edge that sets to_pulse[i], cleared by clr[i], and set SHALL win over a simultaneous clr[i].
REQ-026 to_flag SHALL be unaffected by en, IDLE, or state changes.
REQ-027 to_events SHALL add popcount(to_pulse next-state) per cycle and saturate at 255.
REQ-028 ev_clr SHALL load to_events with the popcount of that cycle's new pulses, not zero.
REQ-029 Timing: with limit=L and a steady non-IDLE enabled state, to_cnt SHALL count 0..L and the pulse SHALL appear L+1 cycles after the count starts from 0.
REQ-030 Channels SHALL be fully independent; simultaneous timeouts on all channels SHALL each pulse and flag.
REQ-031 With limit=512, NCH=1, RESTART_ON_CHANGE=0, and en=1, to_cnt SHALL match the legacy single-channel to_cnt cycle for cycle.

Reset
REQ-032 rst high SHALL immediately force to_cnt, to_pulse, to_flag, and to_events to 0, independent of clk.
REQ-033 Reset asserted mid-count or mid-pulse SHALL abort the in-progress count and pulse with no residual strobe after release.
REQ-034 The first counting edge SHALL be the first rising clk edge with rst low.

Verification
REQ-035 Scenario: NCH=4, limit=5, ch0 in steady non-IDLE state for 20 cycles -> to_cnt[0] counts 0,1,2,3,4,5,0,...; to_pulse[0] fires at cycles 6, 12, and 18; to_events=3; to_chan=0.
REQ-036 Scenario: ch2 steady with to_cnt=3, state change for 1 cycle -> with RESTART_ON_CHANGE=0, to_cnt holds 3 then resumes at 4; with RESTART_ON_CHANGE=1, to_cnt goes to 0.
REQ-037 Scenario: clr[1] asserted on the same edge as ch1's timeout -> to_flag[1] stays 1; clr[1] on the following cycle -> to_flag[1]=0 and to_any=0.
REQ-038 Scenario: all 4 channels time out on the same edge with to_events=253 -> to_events=255 (saturated), to_pulse=4'b1111, to_chan=0.
REQ-039 Scenario: to_cnt[3]=40 while limit is lowered from 100 to 10 -> ch3 pulses on the next qualifying edge and to_cnt[3]=0.
REQ-040 Scenario: rst asserted asynchronously mid-count with to_cnt[0]=7 and to_flag=4'b0101 -> all outputs are 0 before the next clk edge, and there is no pulse after release.
